octal_reg_file: RTL and testbench

OCTAL_REG_FILE -- requirements
Module: octal_reg_file

---
 rtl/octal_rf_pkg.sv | 14 +
 rtl/octal_reg_file_if.sv | 34 +++
 rtl/rf_word.sv | 42 ++++
 rtl/octal_reg_file.sv | 144 ++++++++++++++
 tb/tb_octal_reg_file.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/octal_rf_pkg.sv
// Shared constants and FSM state type for the octal register file.
package octal_rf_pkg;

    localparam int unsigned DEF_DEPTH   = 8;
    localparam int unsigned DEF_DIGITS  = 5;
    localparam int unsigned DEF_DIGIT_W = 3;
    localparam int unsigned DEF_ADDR_W  = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/octal_reg_file_if.sv
// Write/read/clear bus of the octal register file; master drives requests, slave answers.
interface octal_reg_file_if
    import octal_rf_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DIGITS  = DEF_DIGITS,
    parameter int unsigned DIGIT_W = DEF_DIGIT_W
);
    localparam int unsigned WORD_W = DIGITS * DIGIT_W;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic [DIGITS-1:0] wr_mask;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              clr_req;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_err;
    logic              wr_err;
    logic              busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr, clr_req,
        input  rd_data, rd_valid, rd_err, wr_err, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr, clr_req,
        output rd_data, rd_valid, rd_err, wr_err, busy
    );

endinterface

// File: rtl/rf_word.sv
// One register-file entry: DIGITS x DIGIT_W storage, per-digit write enable, synchronous clear.
module rf_word #(
    parameter int unsigned DIGITS  = 5,
    parameter int unsigned DIGIT_W = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we,
    input  logic                        clr,
    input  logic [DIGITS-1:0]           mask,
    input  logic [DIGITS*DIGIT_W-1:0]   wdata,
    output logic [DIGITS*DIGIT_W-1:0]   q
);
    localparam int unsigned WORD_W = DIGITS * DIGIT_W;

    logic [WORD_W-1:0] word_q, word_d;

    // Clear has priority over a write landing on the same edge.
    always_comb begin
        word_d = word_q;
        if (clr) begin
            word_d = '0;
        end else if (we) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                if (mask[k]) begin
                    word_d[k*DIGIT_W +: DIGIT_W] = wdata[k*DIGIT_W +: DIGIT_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign q = word_q;

endmodule

// File: rtl/octal_reg_file.sv
// Octal register file: masked digit writes, registered reads with write-first bypass,
// range-error pulses and a one-entry-per-cycle clear sweep.
module octal_reg_file
    import octal_rf_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned DIGITS  = DEF_DIGITS,
    parameter int unsigned DIGIT_W = DEF_DIGIT_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    octal_reg_file_if.slave   bus
);
    localparam int unsigned   WORD_W   = DIGITS * DIGIT_W;
    localparam int unsigned   PTR_W    = $clog2(DEPTH);
    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [WORD_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_err_q, rd_err_d;
    logic               wr_err_q, wr_err_d;
    logic               busy_q, busy_d;

    logic [WORD_W-1:0]  word_q [DEPTH];
    logic [DEPTH-1:0]   word_we;
    logic [DEPTH-1:0]   word_clr;
    logic               wr_in_rng, rd_in_rng, wr_go, rd_go;
    logic [WORD_W-1:0]  bit_mask, rd_word, rd_merged;

    // Request qualification: a clear request in IDLE pre-empts the write.
    always_comb begin
        wr_in_rng = {1'b0, bus.wr_addr} < DEPTH_X;
        rd_in_rng = {1'b0, bus.rd_addr} < DEPTH_X;
        wr_go     = bus.wr_en && (state_q == IDLE) && !bus.clr_req && wr_in_rng;
        rd_go     = bus.rd_en && (state_q == IDLE);
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign word_we[i]  = wr_go && (bus.wr_addr == ADDR_W'(i));
        assign word_clr[i] = (state_q == CLEAR) && (clr_ptr_q == PTR_W'(i));

        rf_word #(
            .DIGITS  (DIGITS),
            .DIGIT_W (DIGIT_W)
        ) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (word_we[i]),
            .clr   (word_clr[i]),
            .mask  (bus.wr_mask),
            .wdata (bus.wr_data),
            .q     (word_q[i])
        );
    end

    // Read mux plus write-first merge for a same-address collision.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (bus.rd_addr == ADDR_W'(i)) begin
                rd_word = word_q[i];
            end
        end
        bit_mask = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            bit_mask[k*DIGIT_W +: DIGIT_W] = {DIGIT_W{bus.wr_mask[k]}};
        end
        rd_merged = rd_word;
        if (wr_go && (bus.wr_addr == bus.rd_addr)) begin
            rd_merged = (rd_word & ~bit_mask) | (bus.wr_data & bit_mask);
        end
    end

    // Sweep FSM and registered response generation.
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        wr_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            CLEAR: begin
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                end else begin
                    clr_ptr_d = clr_ptr_q + PTR_W'(1);
                end
            end
        endcase

        if (rd_go) begin
            if (rd_in_rng) begin
                rd_valid_d = 1'b1;
                rd_data_d  = rd_merged;
            end else begin
                rd_err_d  = 1'b1;
                rd_data_d = '0;
            end
        end

        wr_err_d = bus.wr_en && (state_q == IDLE) && !bus.clr_req && !wr_in_rng;
        busy_d   = (state_d == CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clr_ptr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            wr_err_q   <= wr_err_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_err   = rd_err_q;
    assign bus.wr_err   = wr_err_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_octal_reg_file.sv
// Bench for octal_reg_file: default build (dut 0) and DEPTH=5/DIGITS=4/DIGIT_W=4 build (dut 1)
// checked against an array-based behavioural model.
module tb_octal_reg_file;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    octal_reg_file_if #(.ADDR_W(8), .DIGITS(5), .DIGIT_W(3)) bus_a ();
    octal_reg_file_if #(.ADDR_W(8), .DIGITS(4), .DIGIT_W(4)) bus_b ();

    octal_reg_file #(.DEPTH(8), .DIGITS(5), .DIGIT_W(3), .ADDR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    octal_reg_file #(.DEPTH(5), .DIGITS(4), .DIGIT_W(4), .ADDR_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    typedef struct packed {
        logic [15:0] d;
        logic        v;
        logic        re;
        logic        we;
        logic        b;
    } obs_t;

    int checks = 0;
    int errors = 0;

    logic [15:0] mdl [2][8];
    int          busy_left [2];
    logic [15:0] exp_d [2];
    logic        exp_v [2];
    logic        exp_re [2];
    logic        exp_we [2];

    function automatic int depth_of(input int w);  return (w == 0) ? 8 : 5; endfunction
    function automatic int digits_of(input int w); return (w == 0) ? 5 : 4; endfunction
    function automatic int dw_of(input int w);     return (w == 0) ? 3 : 4; endfunction
    function automatic logic [15:0] word_mask(input int w);
        return 16'((1 << (digits_of(w) * dw_of(w))) - 1);
    endfunction
    function automatic logic [4:0] full_mask(input int w);
        return 5'((1 << digits_of(w)) - 1);
    endfunction

    // Replace each selected digit of old with the matching digit of nw.
    function automatic logic [15:0] merge(input int w, input logic [15:0] old,
                                          input logic [15:0] nw, input logic [4:0] m);
        logic [15:0] r;
        logic [15:0] field;
        r = old;
        for (int k = 0; k < digits_of(w); k++) begin
            if (m[k]) begin
                field = 16'(((1 << dw_of(w)) - 1) << (k * dw_of(w)));
                r = (r & ~field) | (nw & field);
            end
        end
        return r & word_mask(w);
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 8; i++) mdl[w][i] = '0;
            busy_left[w] = 0;
            exp_d[w] = '0; exp_v[w] = 1'b0; exp_re[w] = 1'b0; exp_we[w] = 1'b0;
        end
    endtask

    // Outcome of one clock edge: while a sweep is running everything is ignored;
    // otherwise write (dropped under a clear), then read (write-first), then clear.
    task automatic model_edge(input int w, input logic we, input logic [7:0] wa,
                              input logic [15:0] wd, input logic [4:0] wm,
                              input logic re, input logic [7:0] ra, input logic cr);
        exp_v[w] = 1'b0; exp_re[w] = 1'b0; exp_we[w] = 1'b0;
        if (busy_left[w] > 0) begin
            busy_left[w]--;
            return;
        end
        if (we && !cr) begin
            if (int'(wa) < depth_of(w)) mdl[w][wa[2:0]] = merge(w, mdl[w][wa[2:0]], wd, wm);
            else exp_we[w] = 1'b1;
        end
        if (re) begin
            if (int'(ra) < depth_of(w)) begin
                exp_v[w] = 1'b1;
                exp_d[w] = mdl[w][ra[2:0]];
            end else begin
                exp_re[w] = 1'b1;
                exp_d[w]  = '0;
            end
        end
        if (cr) begin
            for (int i = 0; i < 8; i++) mdl[w][i] = '0;
            busy_left[w] = depth_of(w);
        end
    endtask

    task automatic idle_all();
        bus_a.wr_en = 0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.wr_mask = '0;
        bus_a.rd_en = 0; bus_a.rd_addr = '0; bus_a.clr_req = 0;
        bus_b.wr_en = 0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.wr_mask = '0;
        bus_b.rd_en = 0; bus_b.rd_addr = '0; bus_b.clr_req = 0;
    endtask

    // Drive one cycle on dut w (the other idles), advance both models, sample 1 after the edge.
    task automatic step(input int w, input logic we, input logic [7:0] wa,
                        input logic [15:0] wd, input logic [4:0] wm,
                        input logic re, input logic [7:0] ra, input logic cr);
        idle_all();
        if (w == 0) begin
            bus_a.wr_en = we; bus_a.wr_addr = wa; bus_a.wr_data = wd[14:0]; bus_a.wr_mask = wm;
            bus_a.rd_en = re; bus_a.rd_addr = ra; bus_a.clr_req = cr;
        end else begin
            bus_b.wr_en = we; bus_b.wr_addr = wa; bus_b.wr_data = wd; bus_b.wr_mask = wm[3:0];
            bus_b.rd_en = re; bus_b.rd_addr = ra; bus_b.clr_req = cr;
        end
        model_edge(w, we, wa, wd, wm, re, ra, cr);
        model_edge(1 - w, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t obs(input int w);
        obs_t o;
        if (w == 0) begin
            o.d = {1'b0, bus_a.rd_data}; o.v = bus_a.rd_valid; o.re = bus_a.rd_err;
            o.we = bus_a.wr_err; o.b = bus_a.busy;
        end else begin
            o.d = bus_b.rd_data; o.v = bus_b.rd_valid; o.re = bus_b.rd_err;
            o.we = bus_b.wr_err; o.b = bus_b.busy;
        end
        return o;
    endfunction

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0;
        idle_all();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            o = obs(w);
            checks++; if (o.d  !== 16'h0) begin errors++; $display("FAIL reset_rd_data dut%0d got %0h want 0", w, o.d); end
            checks++; if (o.v  !== 1'b0)  begin errors++; $display("FAIL reset_rd_valid dut%0d got %b want 0", w, o.v); end
            checks++; if (o.re !== 1'b0)  begin errors++; $display("FAIL reset_rd_err dut%0d got %b want 0", w, o.re); end
            checks++; if (o.we !== 1'b0)  begin errors++; $display("FAIL reset_wr_err dut%0d got %b want 0", w, o.we); end
            checks++; if (o.b  !== 1'b0)  begin errors++; $display("FAIL reset_busy dut%0d got %b want 0", w, o.b); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read(input int w);
        obs_t o;
        logic [15:0] data;
        data = (w == 0) ? 16'o12345 : 16'hA5C3;
        step(w, 1'b1, 8'd3, data, full_mask(w), 1'b0, 8'd0, 1'b0);
        step(w, 1'b0, 8'd0, 16'h0, 5'h0, 1'b1, 8'd3, 1'b0);
        o = obs(w);
        checks++; if (o.v !== 1'b1) begin errors++; $display("FAIL wr_rd_valid dut%0d got %b want 1", w, o.v); end
        checks++; if (o.d !== data) begin errors++; $display("FAIL wr_rd_data dut%0d got %0h want %0h", w, o.d, data); end
        step(w, 1'b0, 8'd0, 16'h0, 5'h0, 1'b0, 8'd0, 1'b0);
        o = obs(w);
        checks++; if (o.v !== 1'b0) begin errors++; $display("FAIL wr_rd_pulse dut%0d got %b want 0", w, o.v); end
        checks++; if (o.d !== data) begin errors++; $display("FAIL wr_rd_hold dut%0d got %0h want %0h", w, o.d, data); end
    endtask

    task automatic test_masked_collision();
        obs_t o;
        step(0, 1'b1, 8'd2, 16'o77777, 5'h1F, 1'b0, 8'd0, 1'b0);
        step(0, 1'b1, 8'd2, 16'o00000, 5'b00101, 1'b1, 8'd2, 1'b0);
        o = obs(0);
        checks++; if (o.v !== 1'b1)      begin errors++; $display("FAIL collide_valid got %b want 1", o.v); end
        checks++; if (o.d !== 16'o77070) begin errors++; $display("FAIL collide_data got %0o want 77070", o.d); end
        step(0, 1'b0, 8'd0, 16'h0, 5'h0, 1'b1, 8'd2, 1'b0);
        o = obs(0);
        checks++; if (o.d !== 16'o77070) begin errors++; $display("FAIL collide_stored got %0o want 77070", o.d); end
    endtask

    task automatic test_out_of_range();
        obs_t o;
        step(0, 1'b1, 8'd8, 16'o11111, 5'h1F, 1'b0, 8'd0, 1'b0);
        o = obs(0);
        checks++; if (o.we !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b want 1", o.we); end
        step(0, 1'b0, 8'd0, 16'h0, 5'h0, 1'b1, 8'd200, 1'b0);
        o = obs(0);
        checks++; if (o.we !== 1'b0)  begin errors++; $display("FAIL oor_wr_err_pulse got %b want 0", o.we); end
        checks++; if (o.re !== 1'b1)  begin errors++; $display("FAIL oor_rd_err got %b want 1", o.re); end
        checks++; if (o.v  !== 1'b0)  begin errors++; $display("FAIL oor_rd_valid got %b want 0", o.v); end
        checks++; if (o.d  !== 16'h0) begin errors++; $display("FAIL oor_rd_data got %0h want 0", o.d); end
        for (int a = 0; a < 8; a++) begin
            step(0, 1'b0, 8'd0, 16'h0, 5'h0, 1'b1, 8'(a), 1'b0);
            o = obs(0);
            checks++;
            if (o.d !== mdl[0][a]) begin
                errors++; $display("FAIL oor_storage addr %0d got %0o want %0o", a, o.d, mdl[0][a]);
            end
        end
    endtask

    task automatic test_clear_sweep(input int w);
        obs_t o;
        int busy_cnt;
        for (int a = 0; a < depth_of(w); a++) begin
            step(w, 1'b1, 8'(a), 16'($urandom) & word_mask(w), full_mask(w), 1'b0, 8'd0, 1'b0);
        end
        step(w, 1'b1, 8'd1, word_mask(w), full_mask(w), 1'b0, 8'd0, 1'b1);
        o = obs(w);
        busy_cnt = 0;
        if (o.b === 1'b1) busy_cnt = 1;
        // Keep hammering reads, writes and clear requests; all must be ignored.
        for (int c = 0; c < 40 && o.b === 1'b1; c++) begin
            step(w, 1'b1, 8'(c % depth_of(w)), word_mask(w), full_mask(w), 1'b1, 8'd1, 1'b1);
            o = obs(w);
            checks++;
            if (o.v !== 1'b0 || o.re !== 1'b0 || o.we !== 1'b0) begin
                errors++; $display("FAIL sweep_ignore dut%0d got v%b re%b we%b want 000", w, o.v, o.re, o.we);
            end
            if (o.b === 1'b1) busy_cnt++;
        end
        checks++;
        if (busy_cnt != depth_of(w)) begin
            errors++; $display("FAIL sweep_busy_cycles dut%0d got %0d want %0d", w, busy_cnt, depth_of(w));
        end
        for (int a = 0; a < depth_of(w); a++) begin
            step(w, 1'b0, 8'd0, 16'h0, 5'h0, 1'b1, 8'(a), 1'b0);
            o = obs(w);
            checks++;
            if (o.v !== 1'b1 || o.d !== 16'h0) begin
                errors++; $display("FAIL sweep_cleared dut%0d addr %0d got v%b %0h want v1 0", w, a, o.v, o.d);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        obs_t o;
        for (int a = 0; a < 8; a++) step(0, 1'b1, 8'(a), 16'o54321, 5'h1F, 1'b0, 8'd0, 1'b0);
        step(0, 1'b0, 8'd0, 16'h0, 5'h0, 1'b0, 8'd0, 1'b1);
        step(0, 1'b0, 8'd0, 16'h0, 5'h0, 1'b0, 8'd0, 1'b0);
        step(0, 1'b0, 8'd0, 16'h0, 5'h0, 1'b0, 8'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        o = obs(0);
        checks++; if (o.b !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", o.b); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1'b1, 8'd4, 16'o36125, 5'h1F, 1'b0, 8'd0, 1'b0);
        for (int a = 0; a < 8; a++) begin
            step(0, 1'b0, 8'd0, 16'h0, 5'h0, 1'b1, 8'(a), 1'b0);
            o = obs(0);
            checks++;
            if (o.d !== ((a == 4) ? 16'o36125 : 16'h0)) begin
                errors++; $display("FAIL midrst_entry addr %0d got %0o want %0o", a, o.d,
                                   (a == 4) ? 16'o36125 : 16'h0);
            end
        end
    endtask

    task automatic test_random(input int w);
        obs_t o;
        logic we, re, cr;
        logic [7:0] wa, ra;
        logic [15:0] wd;
        logic [4:0] wm;
        for (int c = 0; c < 300; c++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            cr = ($urandom_range(0, 39) == 0);
            wa = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(depth_of(w), 255))
                                             : 8'($urandom_range(0, depth_of(w) - 1));
            ra = ($urandom_range(0, 3) == 0) ? wa
               : ($urandom_range(0, 9) == 0) ? 8'($urandom_range(depth_of(w), 255))
                                             : 8'($urandom_range(0, depth_of(w) - 1));
            wd = 16'($urandom) & word_mask(w);
            wm = 5'($urandom) & full_mask(w);
            step(w, we, wa, wd, wm, re, ra, cr);
            o = obs(w);
            checks++; if (o.v  !== exp_v[w])  begin errors++; $display("FAIL rnd_valid dut%0d cyc %0d got %b want %b", w, c, o.v, exp_v[w]); end
            checks++; if (o.d  !== exp_d[w])  begin errors++; $display("FAIL rnd_data dut%0d cyc %0d got %0h want %0h", w, c, o.d, exp_d[w]); end
            checks++; if (o.re !== exp_re[w]) begin errors++; $display("FAIL rnd_rd_err dut%0d cyc %0d got %b want %b", w, c, o.re, exp_re[w]); end
            checks++; if (o.we !== exp_we[w]) begin errors++; $display("FAIL rnd_wr_err dut%0d cyc %0d got %b want %b", w, c, o.we, exp_we[w]); end
            checks++; if (o.b  !== (busy_left[w] > 0)) begin errors++; $display("FAIL rnd_busy dut%0d cyc %0d got %b want %b", w, c, o.b, busy_left[w] > 0); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read(0);
        test_write_read(1);
        test_masked_collision();
        test_out_of_range();
        test_clear_sweep(0);
        test_clear_sweep(1);
        test_reset_mid_sweep();
        test_random(0);
        test_random(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
